// File: rtl/imm_ext_pipe_if.sv
// Request/response bundle for the immediate generator: decode-side request
// channel and ALU-side result channel, both valid/ready.
interface imm_ext_pipe_if #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned IMM_S_W = 16,
    parameter int unsigned IMM_L_W = 26
);
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         sel_mode;
    logic [IMM_S_W-1:0] imm_s;
    logic [IMM_L_W-1:0] imm_l;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  immediate;
    logic [1:0]         out_mode;

    modport master (
        output in_valid, sel_mode, imm_s, imm_l, out_ready,
        input  in_ready, out_valid, immediate, out_mode
    );

    modport slave (
        input  in_valid, sel_mode, imm_s, imm_l, out_ready,
        output in_ready, out_valid, immediate, out_mode
    );
endinterface

// File: rtl/imm_ext_pipe.sv
// Decode-stage immediate generator: selects and extends the short/long
// immediate, then buffers it in a main register plus a skid entry.
module imm_ext_pipe #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned IMM_S_W = 16,
    parameter int unsigned IMM_L_W = 26
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    imm_ext_pipe_if.slave bus
);
    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, skid_q;
    logic [1:0]        main_mode_q, skid_mode_q;
    logic              in_ready_q;

    logic [DATA_W-1:0] ext;
    logic              acc, drn;
    logic              main_load_new, main_load_skid, skid_load;

    always_comb begin
        ext = '0;
        unique case (bus.sel_mode)
            2'b00: ext = DATA_W'(bus.imm_s);
            2'b01: ext = {{(DATA_W-IMM_S_W){bus.imm_s[IMM_S_W-1]}}, bus.imm_s};
            2'b10: ext = DATA_W'(bus.imm_l);
            2'b11: ext = {bus.imm_s, {(DATA_W-IMM_S_W){1'b0}}};
            default: ext = '0;
        endcase
    end

    assign acc = bus.in_valid && in_ready_q;
    assign drn = (state_q != StEmpty) && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StEmpty;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != StFull);
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: if (acc) state_d = StOne;
                StOne: begin
                    if (acc && !drn)      state_d = StFull;
                    else if (!acc && drn) state_d = StEmpty;
                end
                StFull:  if (drn) state_d = StOne;
                default: state_d = StEmpty;
            endcase
        end
    end

    // Load enables are suppressed by flush; data registers keep stale values.
    always_comb begin
        main_load_new  = 1'b0;
        main_load_skid = 1'b0;
        skid_load      = 1'b0;
        bus.out_valid  = (state_q != StEmpty);
        bus.immediate  = main_q;
        bus.out_mode   = main_mode_q;
        bus.in_ready   = in_ready_q;
        if (!flush) begin
            unique case (state_q)
                StEmpty: main_load_new = acc;
                StOne: begin
                    main_load_new = acc && drn;
                    skid_load     = acc && !drn;
                end
                StFull:  main_load_skid = drn;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q      <= '0;
            main_mode_q <= '0;
            skid_q      <= '0;
            skid_mode_q <= '0;
        end else begin
            if (main_load_new) begin
                main_q      <= ext;
                main_mode_q <= bus.sel_mode;
            end else if (main_load_skid) begin
                main_q      <= skid_q;
                main_mode_q <= skid_mode_q;
            end
            if (skid_load) begin
                skid_q      <= ext;
                skid_mode_q <= bus.sel_mode;
            end
        end
    end
endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
- Registered immediate generator for the decode stage of the image-filter processor.
- Selects the short or long instruction immediate, extends or positions it to the datapath width, and delivers it through a valid/ready interface.
- A 2-entry skid buffer keeps `in_ready` registered so decode can stall without a combinational ready path.
- Sits between instruction decode and the ALU operand mux.

Parameters:
- DATA_W, 32, datapath/output width; must be >= IMM_L_W and > IMM_S_W
- IMM_S_W, 16, short immediate width (I-type)
- IMM_L_W, 26, long immediate width (J-type)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- flush  input  1  synchronous pipeline flush; drops all buffered entries
- in_valid  input  1  decode presents an immediate request
- in_ready  output  1  block can accept a request this cycle (registered)
- sel_mode  input  2  00 zero-ext short, 01 sign-ext short, 10 zero-ext long, 11 upper (short placed in MSBs)
- imm_s  input  IMM_S_W  short immediate field
- imm_l  input  IMM_L_W  long immediate field
- out_valid  output  1  `immediate` holds a valid result
- out_ready  input  1  consumer accepts the result this cycle
- immediate  output  DATA_W  extended immediate
- out_mode  output  2  `sel_mode` that produced `immediate`, travels with the data

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values: `out_valid`=0, `immediate`=0, `out_mode`=0, `in_ready`=1, skid entry invalid and zeroed.
- Extension function, purely combinational before the main register:
  - mode 00: {zeros, imm_s}
  - mode 01: {DATA_W-IMM_S_W copies of imm_s[MSB], imm_s}
  - mode 10: {zeros, imm_l}
  - mode 11: imm_s << (DATA_W-IMM_S_W), low bits zero
- Accept: a transfer occurs when `in_valid` && `in_ready`. Output handshake: a transfer occurs when `out_valid` && `out_ready`.
- Latency: an accepted input appears on `immediate`/`out_valid` the next cycle when the main register is empty or draining.
- Storage: main register (drives outputs) plus one skid register. States, by valid bits:
  - EMPTY: main=0, skid=0
  - ONE: main=1, skid=0
  - FULL: main=1, skid=1
- Transitions (acc = input accepted, drn = output taken):
  - EMPTY: acc -> ONE, data into main.
  - ONE: acc && drn -> ONE, new data into main. acc && !drn -> FULL, new data into skid. !acc && drn -> EMPTY. Otherwise hold.
  - FULL: `in_ready`=0, so no accept. drn -> ONE, skid moves to main. Otherwise hold.
- `in_ready` is registered and equals !skid_valid_next. It is 1 in EMPTY/ONE and 0 in FULL. No combinational path from `out_ready` to `in_ready`.
- Order: strict FIFO. The skid entry is never presented before the main entry.
- Stability: while `out_valid`=1 and `out_ready`=0, `immediate` and `out_mode` are held stable.
- Flush: next state EMPTY and `in_ready`=1. A request presented in the flush cycle is discarded. Data registers keep stale values.
- Reset: `rst` has priority over `flush` and any handshake, and also clears the data registers. Reset mid-transfer discards everything.
- Undefined `sel_mode` does not exist; all 4 codes are legal.

Test Plan:
- Reset, then EMPTY, `out_ready`=1; send mode 01 `imm_s`=0x8001 -> one cycle later `out_valid`=1, `immediate`=0xFFFF8001, `out_mode`=01.
- Back-to-back with `out_ready`=1:
  - mode 00 `imm_s`=0x8001 -> 0x00008001
  - mode 10 `imm_l`=0x3FFFFFF -> 0x03FFFFFF
  - mode 11 `imm_s`=0x1234 -> 0x12340000
  - Expect one result per cycle, in order, `in_ready` constantly 1.
- Backpressure: hold `out_ready`=0 and send A=0x0001 then B=0x0002 (mode 00):
  - After B, `in_ready`=0 and `immediate` stays 0x00000001.
  - Raise `out_ready` -> A then B delivered on consecutive cycles, `in_ready` back to 1 one cycle after the FULL state exits.
- Flush in FULL with `in_valid`=1 -> next cycle `out_valid`=0 and `in_ready`=1; the flushed-cycle request never appears on the output.
- Assert `rst` and `flush` together while in ONE -> all outputs at reset values next cycle.
- Randomised valid/ready with a reference queue model over 10k cycles -> zero mismatches, no lost or duplicated entries, outputs stable while stalled.
